uart_fifo: RTL and testbench
============================

Name: uart_fifo

Overview:
- Parametrised successor to the bootloader UART: 8N1 is generalised to 5–9 data bits, optional parity and 1 or 2 stop bits.
- RX path: 2-FF synchroniser, 3-sample majority vote, RX FIFO with valid/ready output, per-byte framing and parity error flags, sticky overrun flag.
- TX path: single-entry valid/ready holding register feeding the shift register.
- Sits between the host-facing pins and the bootloader command parser / flash engine.

Parameters:
- CLKS_PER_BIT, 1250, clocks per bit at the line rate. 12 MHz/9600. Minimum 8.
- DATA_BITS, 8, data bits per frame. Legal range 5..9.
- PARITY, 0, parity mode. 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits. TX emits 1 or 2. RX checks only the first.
- FIFO_DEPTH, 16, RX FIFO entries. Power of 2, minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx  in  1  serial input, asynchronous, idle high
- tx  out  1  serial output, idle high
- rx_valid  out  1  RX FIFO non-empty
- rx_ready  in  1  consumer accepts head entry
- rx_data  out  DATA_BITS  head data, LSB first on wire
- rx_frame_err  out  1  head entry had stop bit = 0
- rx_parity_err  out  1  head entry parity mismatch. Always 0 when PARITY=0.
- rx_overrun  out  1  sticky: a frame was dropped because the FIFO was full
- rx_overrun_clr  in  1  clears rx_overrun
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  holding register empty
- tx_data  in  DATA_BITS  byte to send
- tx_busy  out  1  shift register active

Behaviour:
- Reset (synchronous, active-high) values:
  - tx=1, tx_ready=1, tx_busy=0.
  - rx_valid=0, rx_overrun=0, FIFO pointers=0.
  - RX and TX FSMs in IDLE. Synchroniser flops set to 1.
  - Reset mid-frame abandons the frame and the tx line returns high the cycle after rst.
- Handshakes:
  - A transfer occurs on a clk edge where valid && ready.
  - tx_valid/tx_data must stay stable until accepted.
  - rx_data and flags are stable while rx_valid && !rx_ready.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
  - Each state lasts CLKS_PER_BIT clocks per bit. STOP lasts STOP_BITS*CLKS_PER_BIT clocks.
  - Holding register is loaded on the tx handshake. tx_ready drops the next cycle.
  - IDLE with a loaded holding register: move to the shift register, raise tx_ready, assert tx_busy.
  - First start-bit clock is the cycle after the transfer. Back-to-back frames have no idle gap.
  - Even parity bit = XOR of data bits. Odd parity bit = its inverse.
- RX FSM: IDLE -> START -> DATA -> PARITY (optional) -> STOP -> IDLE.
  - A falling edge on the synchronised rx starts a bit counter.
  - Each bit is the majority of samples at offsets CPB/2-1, CPB/2, CPB/2+1 within the bit.
  - START with majority=1 is a glitch: return to IDLE, nothing is written.
  - At the mid-point of the stop bit, write {data, frame_err, parity_err} to the FIFO. Return to IDLE immediately so the next start edge is detected.
  - A frame with stop=0 (including break, all zeros) is written with frame_err=1.
  - RX FSM then waits for rx=1 before re-arming.
- FIFO:
  - Write when a frame completes and the FIFO is not full.
  - If full: drop the frame and set rx_overrun. Existing contents are unchanged.
  - Simultaneous write and read on a full FIFO is allowed and does not set overrun, because the read frees the slot.
  - Pointers wrap modulo FIFO_DEPTH using an extra MSB for full/empty.
  - rx_valid rises the cycle after the write. Latency from the stop-bit mid-sample to rx_valid is 1 clock.
- rx_overrun_clr and a new overrun in the same cycle: overrun wins (stays 1).
- Width: counters are $clog2(CLKS_PER_BIT*2)+1 bits. The bit index is $clog2(DATA_BITS)+1 bits. No truncation warnings are permitted.

Test Plan:
- Loopback, CLKS_PER_BIT=16, 8N1: send 0x01,'2','3','4','5' on rx -> same five bytes pop in order, no error flags, FIFO never exceeds 5.
- PARITY=1, DATA_BITS=7: send 0x55 with correct parity, then 0x55 with parity inverted -> first pops with rx_parity_err=0, second with rx_parity_err=1, rx_data=7'h55 both.
- FIFO_DEPTH=4, rx_ready held 0: send 6 frames 0x10..0x15 -> entries 0x10..0x13 retained, rx_overrun=1 after the 5th frame. Then raise rx_ready -> 0x10..0x13 pop in order. rx_overrun_clr -> 0.
- TX: tx_data=0x42 pulsed valid for one clock, second byte 0xA5 queued while busy -> tx waveform is 0 / 01000010 LSB-first / 1 / 0 / 10100101 / 1 with no gap, each bit exactly 16 clocks. tx_ready low only while the holding register is full.
- Errors: 2-clock low glitch on rx -> no FIFO write. Break of 12 bit-times low -> one entry, data=0x00, rx_frame_err=1, no further entries until rx returns high.
- Reset mid-frame: assert rst for 1 clock during TX data bit 3 and RX data bit 4 -> tx=1 next cycle, no partial RX entry, tx_ready=1, rx_valid=0.

Source files
------------

// File: rtl/uart_fifo.sv
// UART with configurable framing: TX valid/ready holding register + shift FSM,
// RX synchroniser + majority-vote FSM feeding a FIFO with per-entry error flags.
//   state    | meaning
//   S_IDLE   | line idle; TX waits for holding reg, RX waits for falling edge
//   S_START  | start bit (RX aborts to IDLE on a glitch)
//   S_DATA   | data bits, LSB first
//   S_PARITY | parity bit, only when PARITY != 0
//   S_STOP   | stop bit(s); RX writes the FIFO at the mid-sample
module uart_fifo #(
    parameter int CLKS_PER_BIT = 1250,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 tx,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun,
    input  logic                 rx_overrun_clr,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT * 2) + 1;
    localparam int BW = $clog2(DATA_BITS) + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_BITS + 2;

    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CPB_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CPB_M2  = CW'(CLKS_PER_BIT - 2);
    localparam logic [CW-1:0] STOP_M1 = CW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] SMP0    = CW'(CLKS_PER_BIT - CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] SMP1    = CW'(CLKS_PER_BIT - 1 - CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] SMP2    = CW'(CLKS_PER_BIT - 2 - CLKS_PER_BIT / 2);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
    localparam logic          PAR_EN   = (PARITY != 0);
    localparam logic          ODD      = (PARITY == 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // ---------------- TX ----------------
    state_t                 tx_state_q, tx_state_d;
    logic [CW-1:0]          tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]          tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
    logic [DATA_BITS-1:0]   tx_hold_q, tx_hold_d;
    logic                   tx_full_q, tx_full_d;
    logic                   tx_par_q, tx_par_d;
    logic                   tx_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_hold_q  <= '0;
            tx_full_q  <= 1'b0;
            tx_par_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_hold_q  <= tx_hold_d;
            tx_full_q  <= tx_full_d;
            tx_par_q   <= tx_par_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_hold_d  = tx_hold_q;
        tx_full_d  = tx_full_q;
        tx_par_d   = tx_par_q;
        tx_load    = 1'b0;
        if (tx_state_q != S_IDLE) tx_cnt_d = tx_cnt_q - CNT_ONE;
        case (tx_state_q)
            S_IDLE: tx_load = tx_full_q;
            S_START: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = S_DATA;
                    tx_cnt_d   = CPB_M1;
                    tx_bit_d   = '0;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_shift_d = tx_shift_q >> 1;
                    tx_cnt_d   = CPB_M1;
                    if (tx_bit_q == BIT_LAST) begin
                        tx_state_d = PAR_EN ? S_PARITY : S_STOP;
                        tx_cnt_d   = PAR_EN ? CPB_M1 : STOP_M1;
                    end else begin
                        tx_bit_d = tx_bit_q + BIT_ONE;
                    end
                end
            end
            S_PARITY: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = S_STOP;
                    tx_cnt_d   = STOP_M1;
                end
            end
            S_STOP: begin
                // a queued byte follows the last stop clock with no idle gap
                if (tx_cnt_q == '0) begin
                    if (tx_full_q) tx_load = 1'b1;
                    else           tx_state_d = S_IDLE;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
        if (tx_load) begin
            tx_state_d = S_START;
            tx_cnt_d   = CPB_M1;
            tx_shift_d = tx_hold_q;
            tx_par_d   = (^tx_hold_q) ^ ODD;
            tx_full_d  = 1'b0;
        end
        if (tx_valid && !tx_full_q) begin
            tx_hold_d = tx_data;
            tx_full_d = 1'b1;
        end
    end

    always_comb begin
        tx = 1'b1;
        case (tx_state_q)
            S_START:  tx = 1'b0;
            S_DATA:   tx = tx_shift_q[0];
            S_PARITY: tx = tx_par_q;
            default:  tx = 1'b1;
        endcase
    end

    assign tx_ready = !tx_full_q;
    assign tx_busy  = (tx_state_q != S_IDLE);

    // ---------------- RX ----------------
    logic                   sync1_q, sync2_q, prev_q;
    state_t                 rx_state_q, rx_state_d;
    logic [CW-1:0]          rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]          rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0]   rx_sh_q, rx_sh_d;
    logic [1:0]             smp_q, smp_d;
    logic                   rx_pe_q, rx_pe_d;
    logic                   maj, mid, last, rx_wr, rx_fe;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            smp_q      <= 2'b11;
            rx_pe_q    <= 1'b0;
        end else begin
            sync1_q    <= rx;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            smp_q      <= smp_d;
            rx_pe_q    <= rx_pe_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        smp_d      = smp_q;
        rx_pe_d    = rx_pe_q;
        rx_wr      = 1'b0;
        rx_fe      = 1'b0;
        maj  = (smp_q[0] & smp_q[1]) | (smp_q[0] & sync2_q) | (smp_q[1] & sync2_q);
        mid  = (rx_cnt_q == SMP2);
        last = (rx_cnt_q == '0);
        if (rx_state_q != S_IDLE) begin
            rx_cnt_d = last ? CPB_M1 : rx_cnt_q - CNT_ONE;
            if (rx_cnt_q == SMP0) smp_d[0] = sync2_q;
            if (rx_cnt_q == SMP1) smp_d[1] = sync2_q;
        end
        case (rx_state_q)
            S_IDLE: begin
                // edge cycle is bit offset 0, so the next cycle is offset 1
                if (prev_q && !sync2_q) begin
                    rx_state_d = S_START;
                    rx_cnt_d   = CPB_M2;
                    rx_pe_d    = 1'b0;
                end
            end
            S_START: begin
                if (mid && maj) begin
                    rx_state_d = S_IDLE;
                end else if (last) begin
                    rx_state_d = S_DATA;
                    rx_bit_d   = '0;
                end
            end
            S_DATA: begin
                if (mid) rx_sh_d = {maj, rx_sh_q[DATA_BITS-1:1]};
                if (last) begin
                    if (rx_bit_q == BIT_LAST) rx_state_d = PAR_EN ? S_PARITY : S_STOP;
                    else                      rx_bit_d   = rx_bit_q + BIT_ONE;
                end
            end
            S_PARITY: begin
                if (mid)  rx_pe_d    = maj ^ (^rx_sh_q) ^ ODD;
                if (last) rx_state_d = S_STOP;
            end
            S_STOP: begin
                if (mid) begin
                    rx_wr      = 1'b1;
                    rx_fe      = !maj;
                    rx_state_d = S_IDLE;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // ---------------- RX FIFO ----------------
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic          ovr_q, ovr_d;
    logic          empty, full, rd_en, wr_en;
    logic [EW-1:0] head;

    always_comb begin
        empty  = (wptr_q == rptr_q);
        full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        rd_en  = !empty && rx_ready;
        // a pop in the same cycle frees the slot the write needs
        wr_en  = rx_wr && (!full || rd_en);
        wptr_d = wr_en ? wptr_q + PTR_ONE : wptr_q;
        rptr_d = rd_en ? rptr_q + PTR_ONE : rptr_q;
        ovr_d  = ovr_q;
        if (rx_overrun_clr)  ovr_d = 1'b0;
        if (rx_wr && !wr_en) ovr_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovr_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovr_q  <= ovr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= {rx_sh_q, rx_fe, rx_pe_q};
    end

    assign head          = mem_q[rptr_q[AW-1:0]];
    assign rx_data       = head[EW-1:2];
    assign rx_frame_err  = head[1];
    assign rx_parity_err = PAR_EN & head[0];
    assign rx_valid      = !empty;
    assign rx_overrun    = ovr_q;
endmodule

// File: tb/tb_uart_fifo.sv
// Bench for uart_fifo: instance A (8N1, 4-deep FIFO) and instance B (7E1) checked
// against a frame-level queue model plus literal expectations.
module tb_uart_fifo;
    localparam int CPB = 16;

    typedef struct packed {
        logic [8:0] d;
        logic       fe;
        logic       pe;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_a = 1'b1, tx_a, rxv_a, rxr_a = 1'b0, fe_a, pe_a, ovr_a, clr_a = 1'b0;
    logic       txv_a = 1'b0, txr_a, busy_a;
    logic [7:0] rxd_a, txd_a = 8'h00;
    logic       rx_b = 1'b1, tx_b, rxv_b, rxr_b = 1'b1, fe_b, pe_b, ovr_b;
    logic       txr_b, busy_b;
    logic [6:0] rxd_b;

    int total = 0;
    int bad   = 0;

    ent_t exp_a[$], exp_b[$], log_a[$], log_b[$];
    logic exp_ovr_a = 1'b0;
    logic wave[$];
    logic samp[320];
    int   errcnt[20];

    always #5 clk = ~clk;

    uart_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .tx(tx_a),
        .rx_valid(rxv_a), .rx_ready(rxr_a), .rx_data(rxd_a),
        .rx_frame_err(fe_a), .rx_parity_err(pe_a), .rx_overrun(ovr_a), .rx_overrun_clr(clr_a),
        .tx_valid(txv_a), .tx_ready(txr_a), .tx_data(txd_a), .tx_busy(busy_a));

    uart_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .tx(tx_b),
        .rx_valid(rxv_b), .rx_ready(rxr_b), .rx_data(rxd_b),
        .rx_frame_err(fe_b), .rx_parity_err(pe_b), .rx_overrun(ovr_b), .rx_overrun_clr(1'b0),
        .tx_valid(1'b0), .tx_ready(txr_b), .tx_data(7'h00), .tx_busy(busy_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int which, input logic v);
        if (which == 0) rx_a = v;
        else            rx_b = v;
    endtask

    task automatic model_push(input int which, input ent_t e);
        if (which == 0) begin
            if (exp_a.size() >= 4) exp_ovr_a = 1'b1;
            else                   exp_a.push_back(e);
        end else begin
            exp_b.push_back(e);
        end
    endtask

    // Drives one frame on the chosen rx line; parity bit (if any) is even-parity-checked
    task automatic send(input int which, input logic [8:0] d, input int nb,
                        input bit wp, input logic pb, input logic sb);
        ent_t e;
        logic p;
        p = 1'b0;
        for (int i = 0; i < nb; i++) p ^= d[i];
        e.d  = d;
        e.fe = !sb;
        e.pe = wp && (pb != p);
        model_push(which, e);
        set_rx(which, 1'b0);
        clocks(CPB);
        for (int i = 0; i < nb; i++) begin
            set_rx(which, d[i]);
            clocks(CPB);
        end
        if (wp) begin
            set_rx(which, pb);
            clocks(CPB);
        end
        set_rx(which, sb);
        clocks(CPB);
        set_rx(which, 1'b1);
        clocks(2);
    endtask

    task automatic wait_drain(input int which, input string nm);
        int n;
        n = 0;
        while (((which == 0) ? exp_a.size() : exp_b.size()) != 0 && n < 200) begin
            clocks(1);
            n++;
        end
        chk(nm, (which == 0) ? exp_a.size() : exp_b.size(), 0);
    endtask

    task automatic add_frame(input logic [7:0] d);
        wave.push_back(1'b0);
        for (int i = 0; i < 8; i++) wave.push_back(d[i]);
        wave.push_back(1'b1);
    endtask

    // Pop checker: every handshake must match the head of the model queue
    always @(negedge clk) begin
        ent_t e;
        if (!rst && rxv_a && rxr_a) begin
            if (exp_a.size() == 0) begin
                total++; bad++;
                $display("FAIL pop_a_unexpected: got data %0h, no entry expected", rxd_a);
            end else begin
                e = exp_a.pop_front();
                chk("a_data", 32'(rxd_a), 32'(e.d));
                chk("a_frame_err", 32'(fe_a), 32'(e.fe));
                chk("a_parity_err", 32'(pe_a), 32'(e.pe));
            end
            log_a.push_back('{d: {1'b0, rxd_a}, fe: fe_a, pe: pe_a});
        end
        if (!rst && rxv_b && rxr_b) begin
            if (exp_b.size() == 0) begin
                total++; bad++;
                $display("FAIL pop_b_unexpected: got data %0h, no entry expected", rxd_b);
            end else begin
                e = exp_b.pop_front();
                chk("b_data", 32'(rxd_b), 32'(e.d));
                chk("b_frame_err", 32'(fe_b), 32'(e.fe));
                chk("b_parity_err", 32'(pe_b), 32'(e.pe));
            end
            log_b.push_back('{d: {2'b00, rxd_b}, fe: fe_b, pe: pe_b});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lb_bytes [5];
        logic [7:0] frame_d;
        int txr_err, busy_err;

        // reset values
        clocks(3);
        chk("rst_tx", tx_a, 1);
        chk("rst_tx_ready", txr_a, 1);
        chk("rst_tx_busy", busy_a, 0);
        chk("rst_rx_valid", rxv_a, 0);
        chk("rst_overrun", ovr_a, 0);
        chk("rst_rx_valid_b", rxv_b, 0);
        rst = 1'b0;
        clocks(4);

        // loopback-style stream with the consumer always ready
        lb_bytes[0] = 8'h01; lb_bytes[1] = 8'h32; lb_bytes[2] = 8'h33;
        lb_bytes[3] = 8'h34; lb_bytes[4] = 8'h35;
        rxr_a = 1'b1;
        log_a.delete();
        for (int i = 0; i < 5; i++) send(0, {1'b0, lb_bytes[i]}, 8, 1'b0, 1'b0, 1'b1);
        wait_drain(0, "lb_drained");
        chk("lb_count", log_a.size(), 5);
        for (int i = 0; i < 5 && i < log_a.size(); i++) begin
            chk("lb_literal", 32'(log_a[i].d), 32'(lb_bytes[i]));
            chk("lb_flags", {30'd0, log_a[i].fe, log_a[i].pe}, 0);
        end
        chk("lb_no_overrun", ovr_a, 0);
        clocks(CPB);

        // 7E1: correct parity then inverted parity
        log_b.delete();
        send(1, 9'h055, 7, 1'b1, 1'b0, 1'b1);
        send(1, 9'h055, 7, 1'b1, 1'b1, 1'b1);
        wait_drain(1, "par_drained");
        chk("par_count", log_b.size(), 2);
        if (log_b.size() == 2) begin
            chk("par_first_data", 32'(log_b[0].d), 32'h55);
            chk("par_first_pe", log_b[0].pe, 0);
            chk("par_second_data", 32'(log_b[1].d), 32'h55);
            chk("par_second_pe", log_b[1].pe, 1);
        end

        // overflow of the 4-deep FIFO with the consumer stalled
        rxr_a = 1'b0;
        log_a.delete();
        for (int i = 0; i < 6; i++) begin
            send(0, 9'h010 + 9'(i), 8, 1'b0, 1'b0, 1'b1);
            if (i == 3) begin
                chk("ovr_after4", ovr_a, exp_ovr_a);
                chk("ovr_after4_lit", ovr_a, 0);
                chk("ovr_valid_held", rxv_a, 1);
                chk("ovr_head_held", rxd_a, 8'h10);
            end
            if (i == 4) begin
                chk("ovr_after5", ovr_a, exp_ovr_a);
                chk("ovr_after5_lit", ovr_a, 1);
            end
        end
        rxr_a = 1'b1;
        wait_drain(0, "ovr_drained");
        clocks(2);
        chk("ovr_pop_count", log_a.size(), 4);
        for (int i = 0; i < 4 && i < log_a.size(); i++)
            chk("ovr_pop_literal", 32'(log_a[i].d), 32'h10 + 32'(i));
        chk("ovr_sticky", ovr_a, 1);
        clr_a = 1'b1;
        clocks(1);
        clr_a = 1'b0;
        exp_ovr_a = 1'b0;
        chk("ovr_cleared", ovr_a, 0);
        rxr_a = 1'b0;
        clocks(CPB);

        // TX: 0x42 then 0xA5 queued while busy
        wave.delete();
        add_frame(8'h42);
        add_frame(8'hA5);
        txd_a = 8'h42;
        txv_a = 1'b1;
        chk("tx_ready_idle", txr_a, 1);
        clocks(1);
        txv_a = 1'b0;
        chk("tx_line_after_hs", tx_a, 1);
        chk("tx_ready_holding", txr_a, 0);
        clocks(1);
        chk("tx_ready_after_move", txr_a, 1);
        txd_a = 8'hA5;
        txv_a = 1'b1;
        txr_err = 0;
        busy_err = 0;
        for (int b = 0; b < 20; b++) errcnt[b] = 0;
        for (int k = 0; k < 320; k++) begin
            if (k == 1) txv_a = 1'b0;
            samp[k] = tx_a;
            if (tx_a !== wave[k / CPB]) errcnt[k / CPB]++;
            if (txr_a !== ((k >= 1 && k < 160) ? 1'b0 : 1'b1)) txr_err++;
            if (busy_a !== 1'b1) busy_err++;
            clocks(1);
        end
        for (int b = 0; b < 20; b++) chk($sformatf("tx_bit%0d_bad_clocks", b), errcnt[b], 0);
        chk("tx_ready_profile_bad_clocks", txr_err, 0);
        chk("tx_busy_profile_bad_clocks", busy_err, 0);
        chk("tx_k15_start", samp[15], 0);
        chk("tx_k40_d1", samp[40], 1);
        chk("tx_k159_stop", samp[159], 1);
        chk("tx_k168_start2", samp[168], 0);
        chk("tx_k176_a5_d0", samp[176], 1);
        chk("tx_idle_after", tx_a, 1);
        chk("tx_busy_after", busy_a, 0);

        // 2-clock glitch must not write
        rxr_a = 1'b0;
        rx_a = 1'b0;
        clocks(2);
        rx_a = 1'b1;
        clocks(3 * CPB);
        chk("glitch_no_write", rxv_a, 0);

        // break: 12 bit-times low gives one framing-error entry
        model_push(0, '{d: 9'h000, fe: 1'b1, pe: 1'b0});
        rx_a = 1'b0;
        clocks(12 * CPB);
        chk("brk_valid", rxv_a, 1);
        chk("brk_data", rxd_a, 8'h00);
        chk("brk_frame_err", fe_a, 1);
        rxr_a = 1'b1;
        clocks(1);
        rxr_a = 1'b0;
        clocks(4 * CPB);
        chk("brk_single_entry", rxv_a, 0);
        rx_a = 1'b1;
        clocks(3 * CPB);
        chk("brk_rearm_no_entry", rxv_a, 0);
        chk("brk_model_empty", exp_a.size(), 0);

        // reset during TX data bit 3 and RX data bit 4
        frame_d = 8'h5A;
        for (int c = 0; c < 91; c++) begin
            if (c < CPB)           rx_a = 1'b0;
            else if (c < 9 * CPB)  rx_a = frame_d[(c - CPB) / CPB];
            else                   rx_a = 1'b1;
            if (c == CPB) begin
                txd_a = 8'h42;
                txv_a = 1'b1;
            end
            if (c == CPB + 1) txv_a = 1'b0;
            if (c == 89) begin
                chk("rst_mid_busy", busy_a, 1);
                chk("rst_mid_tx_bit3", tx_a, 0);
            end
            if (c == 90) rst = 1'b1;
            clocks(1);
        end
        rst = 1'b0;
        rx_a = 1'b1;
        chk("rst_mid_tx_high", tx_a, 1);
        chk("rst_mid_tx_ready", txr_a, 1);
        chk("rst_mid_tx_busy", busy_a, 0);
        chk("rst_mid_rx_valid", rxv_a, 0);
        clocks(20 * CPB);
        chk("rst_mid_no_partial", rxv_a, 0);
        chk("rst_mid_tx_idle", tx_a, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
